// File: rtl/banco_registro_rmw_if.sv
// Operand-store bus: two read ports, one read-modify-write port and the
// sweep-clear handshake, shared by the datapath controller and the register bank.
interface banco_registro_rmw_if #(
  parameter int BIT_ADDR = 3,
  parameter int BIT_DATO = 4
);
  logic [BIT_ADDR-1:0] addrRa;
  logic [BIT_ADDR-1:0] addrRb;
  logic [BIT_DATO-1:0] datOutRa;
  logic [BIT_DATO-1:0] datOutRb;
  logic [BIT_ADDR-1:0] addrW;
  logic [BIT_DATO-1:0] datW;
  logic                RegWrite;
  logic [1:0]          wMode;
  logic                clrReq;
  logic                clrBusy;
  logic                clrDone;
  logic                wrDrop;

  modport master (
    output addrRa, addrRb, addrW, datW, RegWrite, wMode, clrReq,
    input  datOutRa, datOutRb, clrBusy, clrDone, wrDrop
  );

  modport slave (
    input  addrRa, addrRb, addrW, datW, RegWrite, wMode, clrReq,
    output datOutRa, datOutRb, clrBusy, clrDone, wrDrop
  );
endinterface

// File: rtl/banco_registro_rmw.sv
// Parametrised 2-read/1-write register bank with read-modify-write modes,
// optional write-through bypass, optional hard-zero reg0 and a sweep-clear engine.
module banco_registro_rmw #(
  parameter int BIT_ADDR  = 3,
  parameter int BIT_DATO  = 4,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input logic clk,
  input logic rst,
  banco_registro_rmw_if.slave bus
);
  localparam int DEPTH = 2 ** BIT_ADDR;
  localparam logic [BIT_ADDR-1:0] LAST_PTR = BIT_ADDR'(DEPTH - 1);
  localparam logic [BIT_ADDR-1:0] ONE_PTR  = BIT_ADDR'(1);
  localparam bit ZERO_ON   = (ZERO_REG0 != 0);
  localparam bit BYPASS_ON = (BYPASS != 0);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t              state_r;
  logic [BIT_ADDR-1:0] ptr_r;
  logic [BIT_DATO-1:0] regFile_r [DEPTH];

  logic [BIT_DATO-1:0] old_s;
  logic [BIT_DATO-1:0] wres_s;
  logic                idle_s;
  logic                commit_s;
  logic                bypass_s;
  logic                clearSlot_s;

  // write result computed from the addressed register's current contents
  always_comb begin
    old_s = regFile_r[bus.addrW];
    case (bus.wMode)
      2'b00:   wres_s = bus.datW;
      2'b01:   wres_s = old_s + bus.datW;
      2'b10:   wres_s = old_s | bus.datW;
      2'b11:   wres_s = old_s & ~bus.datW;
      default: wres_s = bus.datW;
    endcase
  end

  assign idle_s      = (state_r == IDLE);
  assign commit_s    = idle_s && bus.RegWrite && !(ZERO_ON && (bus.addrW == '0));
  assign bypass_s    = BYPASS_ON && commit_s;
  // a hard-zero reg0 is never written, not even by the sweep
  assign clearSlot_s = !(ZERO_ON && (ptr_r == '0));

  // read port A, forwarding a committing write when enabled
  always_comb begin
    if (ZERO_ON && (bus.addrRa == '0)) begin
      bus.datOutRa = '0;
    end else if (bypass_s && (bus.addrRa == bus.addrW)) begin
      bus.datOutRa = wres_s;
    end else begin
      bus.datOutRa = regFile_r[bus.addrRa];
    end
  end

  // read port B, same rules as port A
  always_comb begin
    if (ZERO_ON && (bus.addrRb == '0)) begin
      bus.datOutRb = '0;
    end else if (bypass_s && (bus.addrRb == bus.addrW)) begin
      bus.datOutRb = wres_s;
    end else begin
      bus.datOutRb = regFile_r[bus.addrRb];
    end
  end

  assign bus.clrBusy = (state_r == SWEEP);
  assign bus.clrDone = (state_r == SWEEP) && (ptr_r == LAST_PTR);
  assign bus.wrDrop  = (state_r == SWEEP) && bus.RegWrite;

  // register file and sweep-clear FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regFile_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (commit_s) begin
            regFile_r[bus.addrW] <= wres_s;
          end
          if (bus.clrReq) begin
            state_r <= SWEEP;
            ptr_r   <= '0;
          end
        end
        SWEEP: begin
          if (clearSlot_s) begin
            regFile_r[ptr_r] <= '0;
          end
          ptr_r <= ptr_r + ONE_PTR;
          if (ptr_r == LAST_PTR) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          ptr_r   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_banco_registro_rmw.sv
// Self-checking bench for banco_registro_rmw: directed and random steps against
// an array model of the register contents, plus a ZERO_REG0 instance.
module tb_banco_registro_rmw;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  banco_registro_rmw_if #(.BIT_ADDR(3), .BIT_DATO(4)) ifA ();
  banco_registro_rmw_if #(.BIT_ADDR(3), .BIT_DATO(4)) ifZ ();

  banco_registro_rmw #(.BIT_ADDR(3), .BIT_DATO(4), .BYPASS(1), .ZERO_REG0(0)) dutA (
    .clk(clk), .rst(rst), .bus(ifA)
  );
  banco_registro_rmw #(.BIT_ADDR(3), .BIT_DATO(4), .BYPASS(1), .ZERO_REG0(1)) dutZ (
    .clk(clk), .rst(rst), .bus(ifZ)
  );

  int nTests = 0;
  int nFail  = 0;
  logic [3:0] mem [8];

  function automatic logic [3:0] rmw(input logic [3:0] old, input logic [3:0] d, input logic [1:0] m);
    int r;
    case (m)
      2'd0:    r = int'(d);
      2'd1:    r = (int'(old) + int'(d)) % 16;
      2'd2:    r = int'(old | d);
      default: r = int'(old & ~d);
    endcase
    return 4'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweepCount(input bit z, output int busyN, output int doneN, output int doneAt);
    logic b;
    logic d;
    busyN = 0;
    doneN = 0;
    doneAt = 0;
    if (z) ifZ.clrReq = 1'b1;
    else   ifA.clrReq = 1'b1;
    tick();
    ifA.clrReq = 1'b0;
    ifZ.clrReq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      b = z ? ifZ.clrBusy : ifA.clrBusy;
      d = z ? ifZ.clrDone : ifA.clrDone;
      if (!b) break;
      busyN++;
      if (d) begin
        doneN++;
        doneAt = busyN;
      end
      tick();
    end
  endtask

  initial begin
    int bN, dN, dAt;
    logic [2:0] ra, rb, aw;
    logic [3:0] d, expA, expB, wr;
    logic [1:0] m;
    logic       rw;

    rst = 1'b0;
    ifA.addrRa = '0; ifA.addrRb = '0; ifA.addrW = '0; ifA.datW = '0;
    ifA.RegWrite = 1'b0; ifA.wMode = 2'b00; ifA.clrReq = 1'b0;
    ifZ.addrRa = '0; ifZ.addrRb = '0; ifZ.addrW = '0; ifZ.datW = '0;
    ifZ.RegWrite = 1'b0; ifZ.wMode = 2'b00; ifZ.clrReq = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 4'd0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      ifA.addrRa = 3'(i);
      ifA.addrRb = 3'(7 - i);
      #1;
      chk("rst_ra", ifA.datOutRa, 32'd0);
      chk("rst_rb", ifA.datOutRb, 32'd0);
    end
    chk("rst_busy", ifA.clrBusy, 32'd0);
    chk("rst_done", ifA.clrDone, 32'd0);
    chk("rst_drop", ifA.wrDrop, 32'd0);
    rst = 1'b1;
    tick();

    // load reg j = j, read pairs (i, i+4)
    for (int j = 0; j < 8; j++) begin
      ifA.RegWrite = 1'b1; ifA.wMode = 2'b00; ifA.addrW = 3'(j); ifA.datW = 4'(j);
      tick();
      mem[j] = 4'(j);
    end
    ifA.RegWrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifA.addrRa = 3'(i);
      ifA.addrRb = 3'(i + 4);
      #1;
      chk("pair_ra", ifA.datOutRa, 32'(i));
      chk("pair_rb", ifA.datOutRb, 32'(i + 4));
    end

    // add mode wraps modulo 16
    ifA.RegWrite = 1'b1; ifA.wMode = 2'b01; ifA.addrW = 3'd7; ifA.datW = 4'd12;
    tick();
    ifA.RegWrite = 1'b0; mem[7] = 4'd3;
    ifA.addrRa = 3'd7;
    #1;
    chk("add_wrap", ifA.datOutRa, 32'd3);

    // set-bits then clear-bits with same-cycle bypass on port A
    ifA.RegWrite = 1'b1; ifA.wMode = 2'b00; ifA.addrW = 3'd2; ifA.datW = 4'b0101;
    tick();
    ifA.wMode = 2'b10; ifA.datW = 4'b1010;
    tick();
    ifA.RegWrite = 1'b0; ifA.addrRa = 3'd2;
    #1;
    chk("or_bits", ifA.datOutRa, 32'hF);
    ifA.RegWrite = 1'b1; ifA.wMode = 2'b11; ifA.datW = 4'b0011; ifA.addrRb = 3'd3;
    #1;
    chk("bypass_ra", ifA.datOutRa, 32'hC);
    chk("nobypass_rb", ifA.datOutRb, 32'd3);
    tick();
    ifA.RegWrite = 1'b0; mem[2] = 4'hC;
    #1;
    chk("andn_bits", ifA.datOutRa, 32'hC);

    // random traffic against the array model
    for (int n = 0; n < 150; n++) begin
      ra = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7));
      aw = 3'($urandom_range(0, 7)); d = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));  rw = 1'($urandom_range(0, 1));
      ifA.addrRa = ra; ifA.addrRb = rb; ifA.addrW = aw; ifA.datW = d;
      ifA.wMode = m; ifA.RegWrite = rw;
      wr = rmw(mem[aw], d, m);
      expA = (rw && ra == aw) ? wr : mem[ra];
      expB = (rw && rb == aw) ? wr : mem[rb];
      #1;
      chk("rand_ra", ifA.datOutRa, 32'(expA));
      chk("rand_rb", ifA.datOutRb, 32'(expB));
      chk("rand_drop", ifA.wrDrop, 32'd0);
      tick();
      if (rw) mem[aw] = wr;
    end
    ifA.RegWrite = 1'b0;

    // fill 1..8; last write shares its edge with clrReq
    for (int i = 0; i < 8; i++) begin
      ifA.RegWrite = 1'b1; ifA.wMode = 2'b00; ifA.addrW = 3'(i); ifA.datW = 4'(i + 1);
      ifA.clrReq = (i == 7);
      tick();
      mem[i] = 4'(i + 1);
    end
    ifA.RegWrite = 1'b0; ifA.clrReq = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ifA.addrRa = 3'(k);
      ifA.addrRb = (k == 3) ? 3'd5 : 3'((k + 7) % 8);
      ifA.RegWrite = (k == 3);
      ifA.addrW = 3'd5; ifA.datW = 4'd9; ifA.wMode = 2'b00;
      ifA.clrReq = (k == 4);
      #1;
      chk("sw_busy", ifA.clrBusy, 32'd1);
      chk("sw_done", ifA.clrDone, (k == 7) ? 32'd1 : 32'd0);
      chk("sw_drop", ifA.wrDrop, (k == 3) ? 32'd1 : 32'd0);
      chk("sw_ra", ifA.datOutRa, 32'(mem[k]));
      chk("sw_rb", ifA.datOutRb, 32'(mem[ifA.addrRb]));
      tick();
      mem[k] = 4'd0;
    end
    ifA.RegWrite = 1'b0; ifA.clrReq = 1'b0;
    #1;
    chk("post_busy", ifA.clrBusy, 32'd0);
    chk("post_done", ifA.clrDone, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ifA.addrRa = 3'(i); ifA.addrRb = 3'(i + 4);
      #1;
      chk("post_ra", ifA.datOutRa, 32'(mem[i]));
      chk("post_rb", ifA.datOutRb, 32'(mem[i + 4]));
    end

    // reset in the middle of a sweep
    for (int i = 0; i < 8; i++) begin
      ifA.RegWrite = 1'b1; ifA.addrW = 3'(i); ifA.datW = 4'($urandom_range(1, 15));
      tick();
    end
    ifA.RegWrite = 1'b0; ifA.clrReq = 1'b1;
    tick();
    ifA.clrReq = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", ifA.clrBusy, 32'd0);
    chk("abort_done", ifA.clrDone, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ifA.addrRa = 3'(i); ifA.addrRb = 3'(i + 4);
      #1;
      chk("abort_ra", ifA.datOutRa, 32'd0);
      chk("abort_rb", ifA.datOutRb, 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort_hold_done", ifA.clrDone, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 4'd0;
    tick();
    sweepCount(1'b0, bN, dN, dAt);
    chk("fresh_busy_len", 32'(bN), 32'd8);
    chk("fresh_done_cnt", 32'(dN), 32'd1);
    chk("fresh_done_at", 32'(dAt), 32'd8);

    // hard-zero register 0 instance
    ifZ.RegWrite = 1'b1; ifZ.wMode = 2'b00; ifZ.addrW = 3'd0; ifZ.datW = 4'd9; ifZ.addrRa = 3'd0;
    #1;
    chk("z0_nobypass", ifZ.datOutRa, 32'd0);
    tick();
    ifZ.RegWrite = 1'b0;
    #1;
    chk("z0_reads0", ifZ.datOutRa, 32'd0);
    ifZ.RegWrite = 1'b1; ifZ.addrW = 3'd1; ifZ.datW = 4'd9; ifZ.addrRb = 3'd1;
    #1;
    chk("z1_bypass", ifZ.datOutRb, 32'd9);
    tick();
    ifZ.RegWrite = 1'b0;
    #1;
    chk("z1_stored", ifZ.datOutRb, 32'd9);
    sweepCount(1'b1, bN, dN, dAt);
    chk("z_busy_len", 32'(bN), 32'd8);
    chk("z_done_cnt", 32'(dN), 32'd1);
    chk("z_done_at", 32'(dAt), 32'd8);
    #1;
    chk("z1_swept", ifZ.datOutRb, 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/banco_registro_rmw.md
Name: banco_registro_rmw

Overview:
- Parametrised successor to the team's 2-read/1-write register bank.
- Adds configurable width and depth, read-modify-write modes, optional write-through bypass and an optional hard-zero register 0.
- Adds a multi-cycle sweep-clear engine with busy/done handshake.
- Sits between the datapath controller and ALU as the general-purpose operand store.

Parameters:
- BIT_ADDR, 3, address width; DEPTH = 2**BIT_ADDR registers.
- BIT_DATO, 4, register data width.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads show stored value only.
- ZERO_REG0, 0, 1 = register 0 always reads 0 and ignores writes and clears.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; clears all registers and the FSM.
- addrRa  in  BIT_ADDR  read port A address.
- addrRb  in  BIT_ADDR  read port B address.
- datOutRa  out  BIT_DATO  read port A data (combinational).
- datOutRb  out  BIT_DATO  read port B data (combinational).
- addrW  in  BIT_ADDR  write address.
- datW  in  BIT_DATO  write operand.
- RegWrite  in  1  write enable.
- wMode  in  2  00 load, 01 add, 10 set-bits (OR), 11 clear-bits (AND NOT).
- clrReq  in  1  start sweep clear (sampled in IDLE only).
- clrBusy  out  1  high while sweep in progress.
- clrDone  out  1  one-cycle pulse on the final sweep cycle.
- wrDrop  out  1  one-cycle pulse when a RegWrite is rejected during a sweep.

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - All registers = 0; FSM = IDLE; sweep pointer = 0.
  - clrBusy = clrDone = wrDrop = 0.
  - Reset mid-sweep aborts the sweep with no clrDone pulse.
- Reads: datOutRx = reg[addrRx], zero-latency combinational. If ZERO_REG0=1 and addrRx=0, the output is 0.
- Write result wres, computed from old = reg[addrW], modulo 2**BIT_DATO:
  - 00: wres = datW.
  - 01: wres = old + datW, truncated; no carry out.
  - 10: wres = old | datW.
  - 11: wres = old & ~datW.
- Write commit: in IDLE with RegWrite=1, reg[addrW] <= wres on the rising edge. Skipped if ZERO_REG0=1 and addrW=0.
- Bypass:
  - Applies when BYPASS=1, RegWrite=1, FSM=IDLE and the write is not to a zero-forced reg0.
  - Any read port with addrRx == addrW shows wres in the same cycle.
  - Both ports may bypass at once.
- FSM states IDLE and SWEEP:
  - IDLE -> SWEEP: clrReq=1 at a rising edge; ptr <= 0; clrBusy = 1 from the next cycle.
  - In SWEEP, each cycle reg[ptr] <= 0 and ptr <= ptr+1; reg0 is left untouched when ZERO_REG0=1 (it already reads 0).
  - Exit: the cycle with ptr = DEPTH-1 clears the last register and asserts clrDone. Next edge: FSM = IDLE, clrBusy = 0.
  - Sweep length is exactly DEPTH cycles with clrBusy high.
- Simultaneous events:
  - clrReq and RegWrite at the same IDLE edge: the write commits, then the sweep starts.
  - RegWrite while clrBusy: no register change and no bypass; wrDrop pulses in that cycle.
  - clrReq while clrBusy: ignored; the sweep is not restarted.
- Reads during SWEEP return current contents: swept registers read 0, unswept registers keep their old values.
- Pointer wrap-around is not possible; SWEEP always exits at DEPTH-1.

Test Plan:
- Reset with defaults (BIT_ADDR=3, BIT_DATO=4) -> all 8 registers read 0 on both ports; clrBusy=clrDone=wrDrop=0.
- Load reg j = j for j=0..7, then read pairs (i, i+4) -> datOutRa=i, datOutRb=i+4. Then add mode, addrW=7, datW=12 -> reg7 = 3 (wrap).
- wMode=10, reg2=0101, datW=1010 -> 1111; then wMode=11, datW=0011 -> 1100. With addrRa=2 during the write and BYPASS=1, datOutRa shows 1100 in the same cycle.
- Fill 1..8, pulse clrReq:
  - clrBusy is high for exactly 8 cycles; clrDone pulses once on the 8th.
  - RegWrite to reg5 mid-sweep -> wrDrop pulse and reg5 stays 0 afterwards.
  - All registers read 0 after the sweep.
- Drop rst low on sweep cycle 3 -> all registers 0 immediately, clrBusy=0, no clrDone; a later clrReq starts a fresh 8-cycle sweep.
- ZERO_REG0=1: load reg0 with 9 -> reads 0; bypass is not applied to reg0; a sweep still takes 8 cycles.
